pipe_control: RTL

//  Next-gen control unit for the 5-stage RISC-V core: decodes ID instruction, carries control through ID/EX, EX/MEM, MEM/WB regs.

---
 rtl/pipe_control.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_control.sv
// Pipeline control for the 5-stage core: ID decode, ID/EX, EX/MEM and MEM/WB control registers, and hazard handling.
// Define CTRL_MUL_EN to decode MUL and enable the multi-cycle MUL stall FSM; otherwise MUL decodes as illegal.
module pipe_control #(
    parameter int ALU_OP_W    = 3,
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [31:0]           in_instruction,
    input  logic                  in_branch_taken,
    output logic                  out_stall,
    output logic                  out_flush,
    output logic                  out_illegal,
    output logic                  EX_alu_src,
    output logic [ALU_OP_W-1:0]   EX_alu_op,
    output logic                  MEM_mem_write,
    output logic                  MEM_mem_read,
    output logic                  MEM_branch_inst,
    output logic                  WB_write_mem_to_reg,
    output logic                  WB_write_enable,
    output logic [REG_ADDR_W-1:0] WB_rd
);

    if (MUL_LATENCY < 1) begin : g_bad_mul_latency
        $error("pipe_control: MUL_LATENCY must be >= 1");
    end

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_BR  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_R   = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_I   = ALU_OP_W'(3);
`ifdef CTRL_MUL_EN
    localparam logic [ALU_OP_W-1:0] ALU_MUL = ALU_OP_W'(4);
    localparam int                  CNT_W   = $clog2(MUL_LATENCY + 1);
`endif

    typedef struct packed {
        logic                  valid;
        logic                  alu_src;
        logic [ALU_OP_W-1:0]   alu_op;
        logic                  mem_write;
        logic                  mem_read;
        logic                  branch;
        logic                  mem_to_reg;
        logic                  wen;
        logic [REG_ADDR_W-1:0] rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic                  mem_write;
        logic                  mem_read;
        logic                  branch;
        logic                  mem_to_reg;
        logic                  wen;
        logic [REG_ADDR_W-1:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic                  mem_to_reg;
        logic                  wen;
        logic [REG_ADDR_W-1:0] rd;
    } wb_ctrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd_field;
    logic       mul_enc;

    assign opcode   = in_instruction[6:0];
    assign rd_field = in_instruction[11:7];
    assign funct3   = in_instruction[14:12];
    assign rs1      = in_instruction[19:15];
    assign rs2      = in_instruction[24:20];
    assign funct7   = in_instruction[31:25];
    assign mul_enc  = (opcode == OPC_OP) && (funct7 == 7'b0000001) && (funct3 == 3'b000);

    ex_ctrl_t  dec;
    logic      dec_illegal;
    logic      uses_rs1;
    logic      uses_rs2;
`ifdef CTRL_MUL_EN
    logic      dec_is_mul;
`endif

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
`ifdef CTRL_MUL_EN
        dec_is_mul  = 1'b0;
`endif
        if (in_valid) begin
            dec.valid = 1'b1;
            case (opcode)
                OPC_OP: begin
                    uses_rs1 = 1'b1;
                    uses_rs2 = 1'b1;
                    dec.wen  = 1'b1;
                    if (mul_enc) begin
`ifdef CTRL_MUL_EN
                        dec.alu_op = ALU_MUL;
                        dec_is_mul = 1'b1;
`else
                        dec_illegal = 1'b1;
`endif
                    end else begin
                        dec.alu_op = ALU_R;
                    end
                end
                OPC_LOAD: begin
                    uses_rs1       = 1'b1;
                    dec.alu_src    = 1'b1;
                    dec.alu_op     = ALU_ADD;
                    dec.mem_read   = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.wen        = 1'b1;
                end
                OPC_STORE: begin
                    uses_rs1      = 1'b1;
                    uses_rs2      = 1'b1;
                    dec.alu_src   = 1'b1;
                    dec.alu_op    = ALU_ADD;
                    dec.mem_write = 1'b1;
                end
                OPC_BRANCH: begin
                    uses_rs1   = 1'b1;
                    uses_rs2   = 1'b1;
                    dec.alu_op = ALU_BR;
                    dec.branch = 1'b1;
                end
                OPC_OPIMM: begin
                    uses_rs1    = 1'b1;
                    dec.alu_src = 1'b1;
                    dec.alu_op  = ALU_I;
                    dec.wen     = 1'b1;
                end
                default: dec_illegal = 1'b1;
            endcase
            // Writes to x0 are dropped; rd is only carried for instructions that write.
            if (rd_field == 5'd0) begin
                dec.wen = 1'b0;
            end
            dec.rd = dec.wen ? REG_ADDR_W'(rd_field) : '0;
            if (dec_illegal) begin
                dec      = '0;
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        end
    end

    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
    logic      flush;
    logic      load_use;
    logic      mul_busy;
    logic      advance;

    assign flush    = in_branch_taken;
    assign load_use = ex.valid && ex.mem_read && (ex.rd != '0) &&
                      ((uses_rs1 && (REG_ADDR_W'(rs1) == ex.rd)) ||
                       (uses_rs2 && (REG_ADDR_W'(rs2) == ex.rd)));
    assign advance   = !flush && !mul_busy && !load_use;
    assign out_stall = !flush && (mul_busy || load_use);
    assign out_flush = flush;

`ifdef CTRL_MUL_EN
    typedef enum logic {IDLE, BUSY} mul_state_t;
    mul_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A MUL sits in EX for MUL_LATENCY cycles; all but the last one stall the front end.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (advance && dec_is_mul) begin
                        cnt_next = CNT_W'(MUL_LATENCY - 1);
                        if (MUL_LATENCY > 1) begin
                            state_next = BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_next = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign mul_busy = (state == BUSY);
`else
    assign mul_busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex          <= '0;
            mem         <= '0;
            wb          <= '0;
            out_illegal <= 1'b0;
        end else begin
            // ID/EX: bubble on flush or load-use, hold while a MUL is busy.
            if (flush || (!mul_busy && load_use)) begin
                ex <= '0;
            end else if (!mul_busy) begin
                ex <= dec;
            end
            out_illegal <= advance && dec_illegal;

            // EX/MEM
            if (flush || mul_busy) begin
                mem <= '0;
            end else begin
                mem.mem_write  <= ex.mem_write;
                mem.mem_read   <= ex.mem_read;
                mem.branch     <= ex.branch;
                mem.mem_to_reg <= ex.mem_to_reg;
                mem.wen        <= ex.wen;
                mem.rd         <= ex.rd;
            end

            // MEM/WB
            wb.mem_to_reg <= mem.mem_to_reg;
            wb.wen        <= mem.wen;
            wb.rd         <= mem.rd;
        end
    end

    assign EX_alu_src          = ex.alu_src;
    assign EX_alu_op           = ex.alu_op;
    assign MEM_mem_write       = mem.mem_write;
    assign MEM_mem_read        = mem.mem_read;
    assign MEM_branch_inst     = mem.branch;
    assign WB_write_mem_to_reg = wb.mem_to_reg;
    assign WB_write_enable     = wb.wen;
    assign WB_rd               = wb.rd;

endmodule
